// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow/display double buffering, anti-ghost blanking and leading-zero blanking.
// Latency: outputs are registered, one clock after the scan position / display state they reflect.
// Backpressure: none; load is always accepted and takes effect at the next frame boundary.
//
// Ports:
//   clk, rst        - single clock, asynchronous active-high reset
//   enable          - 1 = scan and drive, 0 = dark with scan counters frozen
//   load            - strobe capturing data_in / dp_in into the shadow register
//   data_in, dp_in  - hex nibble and decimal point per digit (digit 0 least significant)
//   blank_lz        - suppress leading zero digits (digit 0 is never suppressed)
//   seg, dp, an     - active-low segments {a..g}, decimal point, digit enables
//   frame_done      - one-cycle pulse after every frame boundary
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  // Active-low segment pattern {a,b,c,d,e,f,g} for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  logic [PW-1:0]           p_q, p_d;
  logic [DW-1:0]           d_q, d_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    frame_bnd;
  logic                    dark;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [3:0]              cur_nib;

  always_comb begin
    tick      = enable && (p_q == P_LAST);
    frame_bnd = tick && (d_q == D_LAST);

    // Scan position: both counters freeze while disabled.
    p_d = p_q;
    d_d = d_q;
    if (enable) p_d = tick ? '0 : p_q + 1'b1;
    if (tick)   d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;

    // Display only changes on a frame boundary so a frame is never mixed.
    // The transfer uses the pre-edge shadow; a load on the same edge stays pending.
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    pending_d = pending_q;
    if (frame_bnd && pending_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (load) begin
      shadow_d    = data_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    // lz_zero[i] = nibbles i..NUM_DIGITS-1 of the display are all zero.
    lz_zero  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_q[4*i +: 4] == 4'h0);
      lz_zero[i] = zero_run;
    end

    cur_nib = disp_q[4*d_q +: 4];

    // First BLANK_CYCLES of each slot stay dark so the previous digit's
    // segments never ghost onto the newly enabled anode.
    dark  = !enable || (p_q < P_BLANK);
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    an_d  = '1;
    if (!dark) begin
      an_d  = ~(AN_ONE << d_q);
      dp_d  = ~disp_dp_q[d_q];
      seg_d = (blank_lz && (d_q != '0) && lz_zero[d_q]) ? 7'b1111111 : hex_to_seg(cur_nib);
    end

    frame_done_d = frame_bnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q          <= '0;
      d_q          <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 8 cycles per slot, 2 blank cycles).
// Outputs are compared against a behavioural model every cycle plus literal frame checks.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int B  = 2;
  localparam int FR = RD * N;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int n_checks;
  int n_errors;
  bit chk_on;

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scan position derives purely from the number of enabled edges since reset.
  logic [6:0] dec_tab [16];
  initial dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int         m_cnt;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fd;

  function automatic bit m_dark(input int cnt, input logic en);
    return !en || ((cnt % RD) < B);
  endfunction

  function automatic bit m_bnd(input int cnt, input logic en);
    return en && ((cnt % FR) == FR - 1);
  endfunction

  function automatic logic [6:0] m_seg(input int cnt, input logic [15:0] disp,
                                       input logic blz, input logic en);
    int d;
    logic [15:0] upper;
    d = (cnt / RD) % N;
    if (m_dark(cnt, en)) return 7'h7f;
    upper = disp >> (4 * d);
    if (blz && d > 0 && upper == 16'h0) return 7'h7f;
    return dec_tab[upper[3:0]];
  endfunction

  function automatic logic [3:0] m_an(input int cnt, input logic en);
    logic [3:0] a;
    a = 4'hf;
    if (!m_dark(cnt, en)) a[(cnt / RD) % N] = 1'b0;
    return a;
  endfunction

  function automatic logic m_dpo(input int cnt, input logic [3:0] ddp, input logic en);
    if (m_dark(cnt, en)) return 1'b1;
    return ~ddp[(cnt / RD) % N];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= 0;
      m_shadow <= '0;
      m_disp   <= '0;
      m_sdp    <= '0;
      m_ddp    <= '0;
      m_pend   <= 1'b0;
      exp_seg  <= 7'h7f;
      exp_dp   <= 1'b1;
      exp_an   <= 4'hf;
      exp_fd   <= 1'b0;
    end else begin
      exp_seg <= m_seg(m_cnt, m_disp, blank_lz, enable);
      exp_an  <= m_an(m_cnt, enable);
      exp_dp  <= m_dpo(m_cnt, m_ddp, enable);
      exp_fd  <= m_bnd(m_cnt, enable);
      if (m_bnd(m_cnt, enable) && m_pend) begin
        m_disp <= m_shadow;
        m_ddp  <= m_sdp;
      end
      if (load) begin
        m_shadow <= data_in;
        m_sdp    <= dp_in;
        m_pend   <= 1'b1;
      end else if (m_bnd(m_cnt, enable) && m_pend) begin
        m_pend <= 1'b0;
      end
      if (enable) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_seg", {25'd0, seg}, {25'd0, exp_seg});
      chk("model_dp", {31'd0, dp}, {31'd0, exp_dp});
      chk("model_an", {28'd0, an}, {28'd0, exp_an});
      chk("model_frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    chk("frame_done_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called on the falling edge that shows frame_done; checks the following frame.
  // segs = {d3,d2,d1,d0} active-low patterns, dps = expected dp output per digit.
  task automatic check_frame(input string nm, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] a;
    int k;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      chk({nm, "_fd_period"}, {31'd0, frame_done}, {31'd0, (j == 32)});
      if ((j % 8) == 1 || (j % 8) == 2) begin
        chk({nm, "_guard_an"}, {28'd0, an}, 32'hf);
        chk({nm, "_guard_seg"}, {25'd0, seg}, 32'h7f);
      end else if ((j % 8) == 4) begin
        k = (j - 3) / 8;
        a = 4'hf;
        a[k] = 1'b0;
        chk({nm, "_an"}, {28'd0, an}, {28'd0, a});
        chk({nm, "_seg"}, {25'd0, seg}, {25'd0, segs[7*k +: 7]});
        chk({nm, "_dp"}, {31'd0, dp}, {31'd0, dps[k]});
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] msk;

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_on   = 1'b0;
    rst      = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    blank_lz = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", {25'd0, seg}, 32'h7f);
    chk("reset_dp", {31'd0, dp}, 32'd1);
    chk("reset_an", {28'd0, an}, 32'hf);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);
    chk_on = 1'b1;

    // Basic decode and scan order.
    step();
    rst = 1'b0; enable = 1'b1; load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0100;
    step();
    load = 1'b0;
    wait_fd(80);
    check_frame("hex12AF", {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011);

    // Leading-zero blanking.
    step();
    blank_lz = 1'b1; load = 1'b1; data_in = 16'h0050; dp_in = 4'b0000;
    step();
    load = 1'b0;
    wait_fd(80);
    check_frame("lz0050", {7'h7f, 7'h7f, 7'b0100100, 7'b0000001}, 4'b1111);
    step();
    load = 1'b1; data_in = 16'h0000;
    step();
    load = 1'b0;
    wait_fd(80);
    check_frame("lz0000", {7'h7f, 7'h7f, 7'h7f, 7'b0000001}, 4'b1111);

    // Mid-frame load, then a load on the boundary edge itself.
    for (int s = 1; s <= 32; s++) begin
      step();
      case (s)
        1:  blank_lz = 1'b0;
        5:  begin load = 1'b1; data_in = 16'h1111; end
        6:  load = 1'b0;
        31: begin load = 1'b1; data_in = 16'h2222; end
        32: load = 1'b0;
        default: ;
      endcase
    end
    wait_fd(4);
    check_frame("frame1111", {4{7'b1001111}}, 4'b1111);
    check_frame("frame2222", {4{7'b0010010}}, 4'b1111);

    // Enable low mid-slot: dark, counters frozen, resume in place.
    repeat (11) step();
    enable = 1'b0;
    repeat (20) begin
      step();
      @(negedge clk);
      chk("disabled_an", {28'd0, an}, 32'hf);
      chk("disabled_seg", {25'd0, seg}, 32'h7f);
    end
    step();
    enable = 1'b1;
    wait_fd(80);
    check_frame("resume2222", {4{7'b0010010}}, 4'b1111);

    // Reset mid-slot with a load pending: dark immediately, pending discarded.
    repeat (13) step();
    load = 1'b1; data_in = 16'h9999;
    step();
    load = 1'b0;
    rst  = 1'b1;
    #1;
    chk("midreset_seg", {25'd0, seg}, 32'h7f);
    chk("midreset_dp", {31'd0, dp}, 32'd1);
    chk("midreset_an", {28'd0, an}, 32'hf);
    chk("midreset_fd", {31'd0, frame_done}, 32'd0);
    step();
    step();
    rst = 1'b0;
    wait_fd(80);
    check_frame("after_reset", {4{7'b0000001}}, 4'b1111);

    // Randomized phase checked by the model every cycle.
    for (int c = 0; c < 2500; c++) begin
      step();
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 19) == 0);
      blank_lz = $urandom_range(0, 1);
      rst      = ($urandom_range(0, 399) == 0);
      case ($urandom_range(0, 4))
        0:       msk = 16'hFFFF;
        1:       msk = 16'h0FFF;
        2:       msk = 16'h00FF;
        3:       msk = 16'h000F;
        default: msk = 16'h0000;
      endcase
      data_in = 16'($urandom) & msk;
      dp_in   = 4'($urandom);
    end
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (must be > BLANK_CYCLES).
REQ-003 SHALL have parameter BLANK_CYCLES, default 4, anti-ghosting cycles at the start of each slot.
REQ-004 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: enable  input  1  1 = scan and drive display; 0 = display dark, counters hold.
REQ-007 SHALL have port: load  input  1  strobe capturing data_in/dp_in into the shadow register.
REQ-008 SHALL have port: data_in  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant.
REQ-009 SHALL have port: dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 SHALL have port: blank_lz  input  1  1 = leading-zero blanking on.
REQ-011 SHALL have port: seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
REQ-012 SHALL have port: dp  output  1  decimal point, active-low.
REQ-013 SHALL have port: an  output  NUM_DIGITS  digit enables, active-low, one-hot-low when driven.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse at every frame boundary.

Function
REQ-015 SHALL keep prescaler p counting 0..REFRESH_DIV-1 and wrapping; tick = (p == REFRESH_DIV-1) with enable=1.
REQ-016 SHALL advance digit counter d on tick, wrapping NUM_DIGITS-1 -> 0; frame boundary = tick with d == NUM_DIGITS-1.
REQ-017 SHALL hold p and d unchanged while enable=0.
REQ-018 SHALL capture data_in/dp_in into shadow and set pending=1 on any edge with load=1, regardless of enable.
REQ-019 SHALL copy shadow (pre-edge value) to display register and clear pending on a frame boundary with pending=1; a load in that same cycle updates shadow and leaves pending=1.
REQ-020 SHALL register all outputs; each edge computes seg/dp/an from pre-edge p, d, display register, blank_lz, enable (one cycle latency).
REQ-021 SHALL drive an all 1, seg 7'b1111111, dp 1 when enable=0 or p < BLANK_CYCLES.
REQ-022 SHALL otherwise drive an[d]=0 only, seg = decode(display nibble d), dp = ~display dp bit d.
REQ-023 SHALL decode 0..F as: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-024 SHALL, with blank_lz=1, force seg=1111111 for digit d>0 when nibbles d..NUM_DIGITS-1 are all zero; digit 0 never blanked; dp unaffected.
REQ-025 SHALL pulse frame_done=1 for exactly the cycle after a frame boundary edge.

Reset
REQ-026 SHALL on rst=1 immediately clear p, d, shadow, display, pending to 0 and set an all 1, seg 7'b1111111, dp 1, frame_done 0.
REQ-027 SHALL start scanning at p=0, d=0 on the first edge after rst deasserts; reset mid-frame discards pending loads.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-028 SHALL test: reset, enable=1, load data_in=16'h12AF, dp_in=4'b0100 -> after first frame_done, slots show d0 seg 0111000, d1 0001000, d2 0010010 with dp=0, d3 1001111; an 1110/1101/1011/0111.
REQ-029 SHALL test: each slot's first 2 cycles -> an=4'b1111, seg=1111111; frame_done period exactly 32 cycles.
REQ-030 SHALL test: blank_lz=1, data_in=16'h0050 -> d3,d2 blank, d1 0100100, d0 0000001; data_in=16'h0000 -> only d0 lit with 0000001.
REQ-031 SHALL test: load 16'h1111 mid-frame then 16'h2222 on frame-boundary cycle -> next frame shows 1111, following frame 2222, no mixed frame.
REQ-032 SHALL test: enable=0 for 20 cycles mid-slot -> outputs dark, resume at same p, d; rst pulsed mid-slot -> outputs dark at once, display 0000 after release.
